// File: rtl/block_fetch_engine_pkg.sv
// Shared geometry constants, FSM encoding and the block pixel address helper
// for the block fetch engine.
package block_fetch_engine_pkg;
  localparam int IMG_W            = 128;
  localparam int IMG_H            = 96;
  localparam int BLK              = 16;
  localparam int MEM_LAT          = 2;
  localparam int FIFO_DEPTH       = 4;
  localparam int BLOCKS_PER_ROW   = IMG_W / BLK;
  localparam int BLOCKS_PER_FRAME = BLOCKS_PER_ROW * (IMG_H / BLK);
  localparam int LAST_FRAME       = 9;
  localparam int FRAME_SIZE       = IMG_W * IMG_H;
  localparam int ADDR_W           = 17;
  localparam int PIX_W            = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_WAIT_BLK, S_WAIT_FRM, S_FINISH
  } state_t;

  // Frame base, then block origin, then raster offset inside the block.
  function automatic int pix_addr(input int frm, input int blk_id, input int idx,
                                  input int img_w, input int img_h, input int bsz);
    int bpr;
    bpr = img_w / bsz;
    return frm * img_w * img_h
         + ((blk_id / bpr) * bsz + idx / bsz) * img_w
         + (blk_id % bpr) * bsz + idx % bsz;
  endfunction
endpackage

// File: rtl/block_fetch_engine_if.sv
// Memory read port and output pixel stream of the block fetch engine.
interface block_fetch_engine_if;
  import block_fetch_engine_pkg::*;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [PIX_W-1:0]  mem_rdata;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;

  modport master (output mem_rd, mem_addr, pix_valid, pix_data,
                  input  mem_rvalid, mem_rdata, pix_ready);
  modport slave  (input  mem_rd, mem_addr, pix_valid, pix_data,
                  output mem_rvalid, mem_rdata, pix_ready);
endinterface

// File: rtl/block_fetch_engine_pix_fifo.sv
// Small synchronous pixel FIFO; a pop at full frees the slot for a same-cycle push.
module pix_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/block_fetch_engine.sv
// Fetches BLKxBLK pixel blocks of the current frame from a fixed-latency memory
// and streams them in raster order through a credit-limited pixel FIFO.
module block_fetch_engine #(
  parameter int IMG_W      = block_fetch_engine_pkg::IMG_W,
  parameter int IMG_H      = block_fetch_engine_pkg::IMG_H,
  parameter int BLK        = block_fetch_engine_pkg::BLK,
  parameter int FIFO_DEPTH = block_fetch_engine_pkg::FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] frame_id,
  input  logic [5:0] block_id,
  input  logic       frame_inc,
  output logic       block_done,
  output logic       frame_done,
  output logic       all_done,
  block_fetch_engine_if.master bus
);
  import block_fetch_engine_pkg::*;

  localparam int NPIX     = BLK * BLK;
  localparam int CNT_W    = $clog2(NPIX);
  localparam int LAST_BLK = (IMG_W / BLK) * (IMG_H / BLK) - 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);

  state_t           state, state_nxt;
  logic [3:0]       lf;
  logic [5:0]       lblk;
  logic [CNT_W-1:0] iss_cnt, acc_cnt;
  logic [CW-1:0]    outstd, fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_dout;
  logic             issue, push, xfer, last_iss, last_acc;

  // Reads in flight plus buffered pixels never exceed the FIFO, so no backpressure
  // toward memory is needed.
  assign issue    = (state == S_FETCH) && !fifo_full &&
                    ((int'(outstd) + int'(fifo_cnt)) < FIFO_DEPTH);
  assign push     = bus.mem_rvalid && (outstd != '0);
  assign xfer     = bus.pix_valid && bus.pix_ready;
  assign last_iss = issue && (iss_cnt == CNT_W'(NPIX - 1));
  assign last_acc = (state == S_DRAIN) && xfer && (acc_cnt == CNT_W'(NPIX - 1));

  assign bus.mem_rd    = issue;
  assign bus.mem_addr  = issue ? ADDR_W'(pix_addr(int'(lf), int'(lblk), int'(iss_cnt),
                                                  IMG_W, IMG_H, BLK)) : '0;
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_dout;
  assign all_done      = (state == S_FINISH);

  pix_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.mem_rdata),
    .pop   (xfer),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    block_done = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    if (last_iss) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (last_acc) begin
          block_done = 1'b1;
          if (lblk != 6'(LAST_BLK)) begin
            state_nxt = S_WAIT_BLK;
          end else begin
            frame_done = 1'b1;
            state_nxt  = (lf == 4'(LAST_FRAME)) ? S_FINISH : S_WAIT_FRM;
          end
        end
      end
      // One cycle lets the sequencer's block_id increment settle before latching.
      S_WAIT_BLK: state_nxt = S_FETCH;
      S_WAIT_FRM: if (frame_inc) state_nxt = S_FETCH;
      S_FINISH:   state_nxt = S_FINISH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lf      <= '0;
      lblk    <= '0;
      iss_cnt <= '0;
      acc_cnt <= '0;
      outstd  <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_FETCH && state_nxt == S_FETCH) begin
        lf   <= frame_id;
        lblk <= (state == S_WAIT_FRM) ? '0 : block_id;
      end
      if (last_acc) begin
        iss_cnt <= '0;
        acc_cnt <= '0;
      end else begin
        if (issue) iss_cnt <= iss_cnt + 1'b1;
        if (xfer)  acc_cnt <= acc_cnt + 1'b1;
      end
      outstd <= outstd + CW'(issue) - CW'(push);
    end
  end
endmodule

// File: tb/tb_block_fetch_engine.sv
// Randomized bench: frame/block sequencer, fixed-latency memory model and an
// address/pixel scoreboard derived from the block address formula.
module tb_block_fetch_engine;
  import block_fetch_engine_pkg::*;

  logic       clk = 0, rst_n = 0, start = 0, frame_inc = 0;
  logic [3:0] frame_id = 1;
  logic [5:0] block_id = 0;
  logic       block_done, frame_done, all_done;

  block_fetch_engine_if bif();

  block_fetch_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_id   (frame_id),
    .block_id   (block_id),
    .frame_inc  (frame_inc),
    .block_done (block_done),
    .frame_done (frame_done),
    .all_done   (all_done),
    .bus        (bif)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_val(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ {7'b0, v[16]} ^ 8'h5A;
  endfunction

  function automatic int ref_addr(input int f, input int b, input int i);
    int row, col;
    row = (b / 8) * 16 + i / 16;
    col = (b % 8) * 16 + i % 16;
    return f * 12288 + row * 128 + col;
  endfunction

  // memory: data returns exactly MEM_LAT cycles after the strobe
  logic [MEM_LAT-1:0]      rv_pipe = '0;
  logic [MEM_LAT-1:0][7:0] rd_pipe = '0;
  logic                    inject  = 0;
  always @(posedge clk) begin
    rv_pipe <= {rv_pipe[MEM_LAT-2:0], bif.mem_rd};
    rd_pipe <= {rd_pipe[MEM_LAT-2:0], mem_val(int'(bif.mem_addr))};
  end
  assign bif.mem_rvalid = rv_pipe[MEM_LAT-1] | inject;
  assign bif.mem_rdata  = inject ? 8'hA5 : rd_pipe[MEM_LAT-1];

  int rdy_mode = 1;  // 0 random, 1 high, 2 low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bif.pix_ready = ($urandom_range(0, 3) != 0);
      1:       bif.pix_ready = 1'b1;
      default: bif.pix_ready = 1'b0;
    endcase
  end

  // frame/block sequencer
  int load_seq = 0, load_ack = 0, load_f = 1, load_b = 0, inc_wait = 0;
  always @(negedge clk) begin
    frame_inc = 0;
    if (load_ack != load_seq) begin
      frame_id = 4'(load_f);
      block_id = 6'(load_b);
      load_ack = load_seq;
      inc_wait = 0;
    end else if (rst_n && block_done) begin
      if (block_id != 47) block_id++;
      else if (frame_id != 9) begin
        block_id = 0;
        inc_wait = $urandom_range(2, 8);
      end
    end else if (inc_wait > 0) begin
      inc_wait--;
      if (inc_wait == 0) begin
        frame_id++;
        frame_inc = 1;
      end
    end
  end

  // reference model and scoreboard
  int n_iss = 0, n_acc = 0, m_frm = 0, m_blk = 0, bd_cnt = 0, cyc = 0;
  int first_addr = 0, addr17 = 0, last_addr = 0, t_first_rd = 0, t_first_xf = 0, t_last_xf = 0;
  int rd_fin_cnt = 0, last_fd = 0;
  bit m_idle = 1, m_fin = 0;
  always @(negedge clk) begin : mon
    bit xf, bd_exp;
    cyc++;
    if (!rst_n) begin
      n_iss = 0; n_acc = 0; m_idle = 1; m_fin = 0;
    end else begin
      xf = bif.pix_valid && bif.pix_ready;
      if (start && m_idle) begin
        m_idle = 0; m_frm = int'(frame_id); m_blk = int'(block_id);
      end
      if (bif.mem_rd) begin
        chk("occupancy", 32'((n_iss - n_acc) < FIFO_DEPTH), 1);
        chk("mem_addr", 32'(bif.mem_addr), ref_addr(m_frm, m_blk, n_iss));
        if (m_fin || m_idle) rd_fin_cnt++;
        if (n_iss == 0) begin first_addr = int'(bif.mem_addr); t_first_rd = cyc; end
        if (n_iss == 16)  addr17 = int'(bif.mem_addr);
        if (n_iss == 255) last_addr = int'(bif.mem_addr);
        n_iss++;
      end
      if (xf) begin
        chk("xfer_has_data", 32'(n_acc < n_iss), 1);
        chk("pix_data", 32'(bif.pix_data), 32'(mem_val(ref_addr(m_frm, m_blk, n_acc))));
        if (n_acc == 0) t_first_xf = cyc;
        t_last_xf = cyc;
      end
      bd_exp = xf && (n_acc == 255);
      chk("block_done", 32'(block_done), 32'(bd_exp));
      chk("frame_done", 32'(frame_done), 32'(bd_exp && m_blk == 47));
      chk("all_done", 32'(all_done), 32'(m_fin));
      if (xf) n_acc++;
      if (bd_exp) begin
        n_iss = 0; n_acc = 0; bd_cnt++; last_fd = int'(frame_done);
        if (m_blk < 47) m_blk++;
        else if (m_frm < 9) begin m_frm++; m_blk = 0; end
        else m_fin = 1;
      end
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_start(input int f, input int b);
    load_f = f; load_b = b; load_seq++;
    cyc_n(2);
    start = 1;
    cyc_n(1);
    start = 0;
  endtask

  task automatic wait_blocks(input int n, input int budget, input string tag);
    int tgt, k;
    tgt = bd_cnt + n;
    k = 0;
    while (bd_cnt < tgt && k < budget) begin @(posedge clk); k++; end
    #1;
    chk(tag, 32'(bd_cnt >= tgt), 1);
  endtask

  task automatic hit_reset();
    rst_n = 0;
    #1;
    chk("rst_mem_rd",     32'(bif.mem_rd), 0);
    chk("rst_mem_addr",   32'(bif.mem_addr), 0);
    chk("rst_pix_valid",  32'(bif.pix_valid), 0);
    chk("rst_pix_data",   32'(bif.pix_data), 0);
    chk("rst_block_done", 32'(block_done), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_all_done",   32'(all_done), 0);
    cyc_n(4);
    rst_n = 1;
  endtask

  task automatic idle_check(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin @(negedge clk); if (bif.mem_rd) seen++; end
    chk(tag, seen, 0);
  endtask

  initial begin
    int k, snap;
    #2;
    hit_reset();
    idle_check(10, "idle_no_rd");
    // stray read data with nothing outstanding
    @(posedge clk); #1 inject = 1;
    @(posedge clk); #1 inject = 0;
    @(negedge clk);
    chk("discard_rvalid", 32'(bif.pix_valid), 0);

    // frame 1 block 0, full throughput
    rdy_mode = 1;
    load_start(1, 0);
    wait_blocks(1, 600, "tmo_blk0");
    chk("b0_first_addr", first_addr, 12288);
    chk("b0_last_addr",  last_addr, 14223);
    chk("b0_latency",    t_first_xf - t_first_rd, MEM_LAT + 1);
    chk("b0_burst",      t_last_xf - t_first_xf, 255);
    chk("b0_frame_done", last_fd, 0);
    rdy_mode = 0;
    wait_blocks(1, 2000, "tmo_blk1");

    // reset at pixel 100 of block 2, then restart it
    k = 0;
    while (n_acc < 100 && k < 2000) begin @(negedge clk); k++; end
    chk("tmo_px100", 32'(n_acc >= 100), 1);
    hit_reset();
    idle_check(6, "post_rst_idle");
    load_start(1, 2);
    wait_blocks(1, 2000, "tmo_restart");
    chk("restart_first_addr", first_addr, 12320);

    // frame 1 block 9 with a 50-cycle downstream stall
    hit_reset();
    rdy_mode = 0;
    load_start(1, 9);
    k = 0;
    while (n_iss < 40 && k < 1000) begin @(negedge clk); k++; end
    rdy_mode = 2;
    cyc_n(10);
    snap = n_iss;
    cyc_n(40);
    chk("stall_no_issue", n_iss, snap);
    chk("stall_occ", n_iss - n_acc, FIFO_DEPTH);
    chk("stall_valid", 32'(bif.pix_valid), 1);
    rdy_mode = 0;
    wait_blocks(1, 2000, "tmo_blk9");
    chk("b9_first_addr", first_addr, 14352);
    chk("b9_r1c0_addr",  addr17, 14480);

    // frame 3 last blocks, frame change
    hit_reset();
    load_start(3, 46);
    wait_blocks(2, 4000, "tmo_f3");
    chk("f3_frame_done", last_fd, 1);
    wait_blocks(1, 2000, "tmo_f4b0");
    chk("f4_first_addr", first_addr, 49152);

    // final block of frame 9
    hit_reset();
    rdy_mode = 1;
    load_start(9, 47);
    wait_blocks(1, 600, "tmo_f9");
    chk("f9_frame_done", last_fd, 1);
    cyc_n(2);
    chk("all_done_set", 32'(all_done), 1);
    start = 1;
    cyc_n(1);
    start = 0;
    cyc_n(50);
    chk("all_done_hold", 32'(all_done), 1);
    chk("fin_no_rd", rd_fin_cnt, 0);
    chk("fin_no_valid", 32'(bif.pix_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1);
  end
endmodule

// File: doc/block_fetch_engine.md
BLOCK_FETCH_ENGINE -- requirements
Module: block_fetch_engine

Interface
REQ-001 Parameters: IMG_W 128, image width in pixels; IMG_H 96, image height in pixels; BLK 16, block edge in pixels; MEM_LAT 2, fixed read latency in cycles; FIFO_DEPTH 4, pixel buffer depth.
REQ-002 clk  in  1  clock; all logic is rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse that leaves IDLE and begins frame fetch.
REQ-005 frame_id  in  4  current frame, 1..9, driven by the frame/block sequencer.
REQ-006 block_id  in  6  current block, 0..47, raster order, 8 blocks per row.
REQ-007 frame_inc  in  1  one-cycle pulse; frame_id is already updated in the same cycle.
REQ-008 block_done  out  1  one-cycle pulse on the last pixel handshake of a block.
REQ-009 frame_done  out  1  one-cycle pulse coincident with block_done when the latched block is 47.
REQ-010 all_done  out  1  level; high after frame 9, block 47 completes.
REQ-011 mem_rd  out  1  read strobe, one pixel per asserted cycle.
REQ-012 mem_addr  out  17  pixel address.
REQ-013 mem_rvalid  in  1  read data valid, exactly MEM_LAT cycles after mem_rd.
REQ-014 mem_rdata  in  8  pixel returned with mem_rvalid.
REQ-015 pix_valid  out  1  output pixel valid.
REQ-016 pix_ready  in  1  downstream accept; transfer = pix_valid & pix_ready.
REQ-017 pix_data  out  8  output pixel, raster order within the block.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN, WAIT_BLK, WAIT_FRM, FINISH.
REQ-019 IDLE -> FETCH on start; the engine latches frame_id/block_id on every entry to FETCH.
REQ-020 Address = lf*IMG_W*IMG_H + (by*BLK + r)*IMG_W + bx*BLK + c, where lf is the latched frame, bx = lblk mod 8, by = lblk div 8, and r,c are 0..15 raster.
REQ-021 mem_rd is asserted only in FETCH, and only when outstanding + fifo_count < FIFO_DEPTH; the FIFO therefore never overflows.
REQ-022 The issue counter runs 0..255; FETCH -> DRAIN in the cycle the 256th read is issued.
REQ-023 mem_rvalid data is pushed into the FIFO; pix_valid = FIFO not empty; pix_data = FIFO head; push and pop in the same cycle are both honoured.
REQ-024 The accept counter runs 0..255; on the 256th transfer the engine pulses block_done and resets both counters.
REQ-025 On the 256th transfer: if lblk < 47, go to WAIT_BLK; if lblk = 47 and lf < 9, pulse frame_done and go to WAIT_FRM; if lblk = 47 and lf = 9, pulse frame_done and go to FINISH.
REQ-026 WAIT_BLK lasts exactly one cycle, so block_id has incremented, then the engine goes to FETCH.
REQ-027 WAIT_FRM holds until frame_inc = 1, then goes to FETCH in the next cycle, with block_id = 0 and the new frame_id latched.
REQ-028 FINISH holds all_done = 1 and ignores start; only reset exits it.
REQ-029 With pix_ready held low, the engine issues at most FIFO_DEPTH reads, then stalls with mem_rd = 0 and no data lost.
REQ-030 mem_rvalid while outstanding = 0 is discarded.
REQ-031 With pix_ready held high, throughput is 1 pixel/cycle after an initial MEM_LAT+1 cycle latency.

Reset
REQ-032 Asynchronous reset (rst_n low) forces state IDLE, all counters, FIFO pointers and outstanding count to 0, and all outputs to 0, at any time including mid-block.
REQ-033 After rst_n release, the engine stays in IDLE until start.

Structure
REQ-034 A shared package holds IMG_W, IMG_H, BLK, BLOCKS_PER_ROW (8), BLOCKS_PER_FRAME (48), LAST_FRAME (9), FRAME_SIZE (12288) and the FSM state encoding.
REQ-035 One sub-module, pix_fifo: a synchronous FIFO of depth FIFO_DEPTH, 8-bit wide, exposing count, full and empty.

Verification
REQ-036 Scenario: frame_id = 1, block_id = 0, start, pix_ready = 1 -> first mem_addr = 12288, last = 14223, 256 pixels, then a block_done pulse with frame_done = 0.
REQ-037 Scenario: frame_id = 1, block_id = 9 -> first mem_addr = 14352, the 17th read (r = 1, c = 0) = 14480.
REQ-038 Scenario: pix_ready = 0 for 50 cycles mid-block -> at most 4 reads outstanding or buffered, mem_rd = 0 while stalled; after release, the pixel sequence equals the memory model contents in order.
REQ-039 Scenario: block 47 of frame 3 completes -> block_done and frame_done are high in the same cycle; the engine waits for frame_inc, then the first address = 4*12288 = 49152.
REQ-040 Scenario: frame 9 block 47 completes -> all_done = 1, no further mem_rd; a start pulse is ignored.
REQ-041 Scenario: rst_n driven low at pixel 100 of a block -> all outputs 0 immediately, state IDLE; after release and start, the block restarts at pixel 0.
